// File: rtl/dma_request_issuer.sv
// dma_request_issuer: turns one DMA chunk into a 3DW MRd/MWr TLP header,
// tracks read completions and pulses dma_done when the chunk is finished.
// Optional completion timeout: define DMA_CPL_TIMEOUT_EN.
module dma_request_issuer #(
    parameter int unsigned CPL_TIMEOUT_CYCLES = 65535
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        dma_pending,
    input  logic [31:0] dma_address_host,
    input  logic [31:0] dma_address_device,
    input  logic [9:0]  dma_size,
    input  logic        dma_dir_write,
    output logic        dma_done,
    input  logic [15:0] requester_id,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [31:0] hdr_dw0,
    output logic [31:0] hdr_dw1,
    output logic [31:0] hdr_dw2,
    input  logic        cpl_valid,
    input  logic [7:0]  cpl_tag,
    input  logic [9:0]  cpl_length_dw,
    input  logic [2:0]  cpl_status,
    output logic [31:0] cpl_wr_address,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        unexp_tag
);

    localparam int unsigned LEN_W = 10;
    localparam int unsigned RCV_W = 11;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ERR_STATUS  = 2'b01;
    localparam logic [1:0] ERR_ZERO_SZ = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // The limit has to fit the 16-bit completion-timeout counter
    if (CPL_TIMEOUT_CYCLES == 0 || CPL_TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("CPL_TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WAIT_CPL,
        DONE,
        ERR
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;
    logic               dir_write_q, dir_write_d;
    logic [LEN_W-1:0]   len_dw_q, len_dw_d;
    logic [31:0]        dev_base_q, dev_base_d;
    logic [RCV_W-1:0]   rcv_dw_q, rcv_dw_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic [31:0]        hdr_dw0_q, hdr_dw0_d;
    logic [31:0]        hdr_dw1_q, hdr_dw1_d;
    logic [31:0]        hdr_dw2_q, hdr_dw2_d;
    logic               dma_done_q, dma_done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               unexp_tag_q, unexp_tag_d;

    logic [LEN_W:0]     size_plus3;
    logic [LEN_W-1:0]   new_len_dw;
    logic [3:0]         size_be;
    logic [3:0]         first_be;
    logic [3:0]         last_be;
    logic [2:0]         new_fmt;
    logic               tag_match;
    logic [RCV_W:0]     rcv_sum;

`ifdef DMA_CPL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CPL_TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    // Length and byte enables of the chunk offered on the request port
    always_comb begin
        size_plus3 = (LEN_W + 1)'(dma_size) + (LEN_W + 1)'(3);
        new_len_dw = LEN_W'(size_plus3 >> 2);
        case (dma_size[1:0])
            2'b01:   size_be = 4'h1;
            2'b10:   size_be = 4'h3;
            2'b11:   size_be = 4'h7;
            default: size_be = 4'hF;
        endcase
        if (new_len_dw == LEN_W'(1)) begin
            first_be = size_be;
            last_be  = 4'h0;
        end else begin
            first_be = 4'hF;
            last_be  = size_be;
        end
        new_fmt = dma_dir_write ? 3'b010 : 3'b000;
    end

    // Completion matching against the chunk in flight
    always_comb begin
        tag_match = (cpl_tag == {3'b000, cur_tag_q});
        rcv_sum   = (RCV_W + 1)'(rcv_dw_q) + (RCV_W + 1)'(cpl_length_dw);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        cur_tag_d   = cur_tag_q;
        dir_write_d = dir_write_q;
        len_dw_d    = len_dw_q;
        dev_base_d  = dev_base_q;
        rcv_dw_d    = rcv_dw_q;
        hdr_dw0_d   = hdr_dw0_q;
        hdr_dw1_d   = hdr_dw1_q;
        hdr_dw2_d   = hdr_dw2_q;
        err_code_d  = err_code_q;
        unexp_tag_d = unexp_tag_q;
`ifdef DMA_CPL_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (dma_pending) begin
                    if (dma_size == LEN_W'(0)) begin
                        state_d    = ERR;
                        err_code_d = ERR_ZERO_SZ;
                    end else begin
                        state_d     = HDR;
                        cur_tag_d   = tag_q;
                        dir_write_d = dma_dir_write;
                        len_dw_d    = new_len_dw;
                        dev_base_d  = dma_address_device;
                        rcv_dw_d    = RCV_W'(0);
                        hdr_dw0_d   = {new_fmt, 5'b00000, 14'b0, new_len_dw};
                        hdr_dw1_d   = {requester_id, 3'b000, tag_q, last_be, first_be};
                        hdr_dw2_d   = dma_address_host & 32'hFFFF_FFFC;
                    end
                end
            end
            HDR: begin
                if (hdr_ready) begin
                    tag_d   = tag_q + TAG_W'(1);
                    state_d = dir_write_q ? DONE : WAIT_CPL;
`ifdef DMA_CPL_TIMEOUT_EN
                    cnt_d   = CNT_W'(0);
`endif
                end
            end
            WAIT_CPL: begin
                if (cpl_valid && tag_match) begin
                    if (cpl_status == 3'b000) begin
                        rcv_dw_d = RCV_W'(rcv_sum);
                        if (rcv_sum >= (RCV_W + 1)'(len_dw_q)) begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d    = ERR;
                        err_code_d = ERR_STATUS;
                    end
`ifdef DMA_CPL_TIMEOUT_EN
                    cnt_d = CNT_W'(0);
`endif
                end else begin
                    if (cpl_valid) begin
                        unexp_tag_d = 1'b1;
                    end
`ifdef DMA_CPL_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == TIMEOUT_LAST) begin
                        state_d    = ERR;
                        err_code_d = ERR_TIMEOUT;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hdr_valid_d = (state_d == HDR);
        dma_done_d  = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

    // State and output registers, synchronous active-high reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            cur_tag_q   <= '0;
            dir_write_q <= 1'b0;
            len_dw_q    <= '0;
            dev_base_q  <= '0;
            rcv_dw_q    <= '0;
            hdr_valid_q <= 1'b0;
            hdr_dw0_q   <= '0;
            hdr_dw1_q   <= '0;
            hdr_dw2_q   <= '0;
            dma_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            unexp_tag_q <= 1'b0;
`ifdef DMA_CPL_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            cur_tag_q   <= cur_tag_d;
            dir_write_q <= dir_write_d;
            len_dw_q    <= len_dw_d;
            dev_base_q  <= dev_base_d;
            rcv_dw_q    <= rcv_dw_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_dw0_q   <= hdr_dw0_d;
            hdr_dw1_q   <= hdr_dw1_d;
            hdr_dw2_q   <= hdr_dw2_d;
            dma_done_q  <= dma_done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            unexp_tag_q <= unexp_tag_d;
`ifdef DMA_CPL_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign dma_done       = dma_done_q;
    assign hdr_valid      = hdr_valid_q;
    assign hdr_dw0        = hdr_dw0_q;
    assign hdr_dw1        = hdr_dw1_q;
    assign hdr_dw2        = hdr_dw2_q;
    assign err            = err_q;
    assign err_code       = err_code_q;
    assign unexp_tag      = unexp_tag_q;
    // Payload address for the completion being presented this cycle
    assign cpl_wr_address = dev_base_q + (32'(rcv_dw_q) << 2);

endmodule

// File: tb/tb_dma_request_issuer.sv
// Directed testbench for dma_request_issuer.
module tb_dma_request_issuer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        dma_pending;
    logic [31:0] dma_address_host;
    logic [31:0] dma_address_device;
    logic [9:0]  dma_size;
    logic        dma_dir_write;
    logic        dma_done;
    logic [15:0] requester_id;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] hdr_dw0;
    logic [31:0] hdr_dw1;
    logic [31:0] hdr_dw2;
    logic        cpl_valid;
    logic [7:0]  cpl_tag;
    logic [9:0]  cpl_length_dw;
    logic [2:0]  cpl_status;
    logic [31:0] cpl_wr_address;
    logic        err;
    logic [1:0]  err_code;
    logic        unexp_tag;

    int n_pass  = 0;
    int n_total = 0;

    dma_request_issuer #(.CPL_TIMEOUT_CYCLES(100)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .dma_pending       (dma_pending),
        .dma_address_host  (dma_address_host),
        .dma_address_device(dma_address_device),
        .dma_size          (dma_size),
        .dma_dir_write     (dma_dir_write),
        .dma_done          (dma_done),
        .requester_id      (requester_id),
        .hdr_valid         (hdr_valid),
        .hdr_ready         (hdr_ready),
        .hdr_dw0           (hdr_dw0),
        .hdr_dw1           (hdr_dw1),
        .hdr_dw2           (hdr_dw2),
        .cpl_valid         (cpl_valid),
        .cpl_tag           (cpl_tag),
        .cpl_length_dw     (cpl_length_dw),
        .cpl_status        (cpl_status),
        .cpl_wr_address    (cpl_wr_address),
        .err               (err),
        .err_code          (err_code),
        .unexp_tag         (unexp_tag)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    endtask

    // {dma_done, hdr_valid, err, err_code, unexp_tag}
    function automatic logic [31:0] flags();
        return {26'b0, dma_done, hdr_valid, err, err_code, unexp_tag};
    endfunction

    task automatic issue(input logic [31:0] host, input logic [31:0] dev,
                         input logic [9:0] size, input logic wr);
        dma_pending        = 1'b1;
        dma_address_host   = host;
        dma_address_device = dev;
        dma_size           = size;
        dma_dir_write      = wr;
        tick();
        dma_pending = 1'b0;
    endtask

    task automatic cpl(input logic [7:0] tag, input logic [9:0] len, input logic [2:0] st);
        cpl_valid     = 1'b1;
        cpl_tag       = tag;
        cpl_length_dw = len;
        cpl_status    = st;
    endtask

    initial begin
        i_rst = 1'b1;
        dma_pending = 1'b0; dma_address_host = '0; dma_address_device = '0;
        dma_size = '0; dma_dir_write = 1'b0; requester_id = 16'h0100;
        hdr_ready = 1'b0; cpl_valid = 1'b0; cpl_tag = '0; cpl_length_dw = '0;
        cpl_status = '0;
        tick(); tick();
        check("reset_flags", flags(), 32'h0);
        check("reset_dw0", hdr_dw0, 32'h0);
        check("reset_dw1", hdr_dw1, 32'h0);
        check("reset_dw2", hdr_dw2, 32'h0);
        check("reset_cpl_addr", cpl_wr_address, 32'h0);
        i_rst = 1'b0;
        tick();

        // Read, 128 bytes, tag 0
        issue(32'h1000_0000, 32'h2000_0000, 10'd128, 1'b0);
        check("rd_hdr_valid", 32'(hdr_valid), 32'h1);
        check("rd_dw0", hdr_dw0, 32'h0000_0020);
        check("rd_dw1", hdr_dw1, 32'h0100_00FF);
        check("rd_dw2", hdr_dw2, 32'h1000_0000);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        check("rd_hdr_drop", 32'(hdr_valid), 32'h0);
        cpl(8'd0, 10'd16, 3'd0);
        #1;
        check("rd_cpl_addr0", cpl_wr_address, 32'h2000_0000);
        tick();
        check("rd_cpl_addr1", cpl_wr_address, 32'h2000_0040);
        check("rd_no_done_yet", 32'(dma_done), 32'h0);
        tick();
        cpl_valid = 1'b0;
        check("rd_done", 32'(dma_done), 32'h1);
        tick();
        check("rd_done_pulse", 32'(dma_done), 32'h0);

        // Write, 256 bytes, tag 1, hdr_ready held off 3 cycles
        issue(32'h3000_0007, 32'h0, 10'd256, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("wr_hold_valid", 32'(hdr_valid), 32'h1);
            check("wr_hold_dw0", hdr_dw0, 32'h4000_0040);
            check("wr_hold_dw1", hdr_dw1, 32'h0100_01FF);
            check("wr_hold_dw2", hdr_dw2, 32'h3000_0004);
            tick();
        end
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        check("wr_done", 32'(dma_done), 32'h1);
        check("wr_hdr_drop", 32'(hdr_valid), 32'h0);
        tick();
        check("wr_done_pulse", 32'(dma_done), 32'h0);

        // Read, 6 bytes, tag 2, with a stray completion first
        issue(32'h0000_0100, 32'h0000_8000, 10'd6, 1'b0);
        check("sz6_dw0", hdr_dw0, 32'h0000_0002);
        check("sz6_dw1", hdr_dw1, 32'h0100_023F);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        cpl(8'd5, 10'd2, 3'd0);
        tick();
        check("stray_flag", 32'(unexp_tag), 32'h1);
        check("stray_no_done", 32'(dma_done), 32'h0);
        cpl(8'd2, 10'd2, 3'd0);
        #1;
        check("sz6_cpl_addr", cpl_wr_address, 32'h0000_8000);
        tick();
        cpl_valid = 1'b0;
        check("sz6_done", 32'(dma_done), 32'h1);
        tick();

        // Write, 3 bytes, tag 3
        issue(32'h0000_0200, 32'h0, 10'd3, 1'b1);
        check("sz3_dw0", hdr_dw0, 32'h4000_0001);
        check("sz3_dw1", hdr_dw1, 32'h0100_0307);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        check("sz3_done", 32'(dma_done), 32'h1);
        tick();

        // Read tag 4, reset while waiting for completions
        issue(32'h0000_0044, 32'h0000_9000, 10'd4, 1'b0);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_flags", flags(), 32'h0);
        check("midrst_dw0", hdr_dw0, 32'h0);
        check("midrst_dw1", hdr_dw1, 32'h0);
        check("midrst_dw2", hdr_dw2, 32'h0);
        check("midrst_cpl_addr", cpl_wr_address, 32'h0);
        cpl(8'd9, 10'd1, 3'd0);
        tick();
        cpl_valid = 1'b0;
        check("idle_cpl_no_flag", 32'(unexp_tag), 32'h0);
        issue(32'h0000_0044, 32'h0000_9000, 10'd4, 1'b0);
        check("post_rst_dw0", hdr_dw0, 32'h0000_0001);
        check("post_rst_dw1_tag0", hdr_dw1, 32'h0100_000F);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        cpl(8'd4, 10'd1, 3'd0);
        tick();
        check("old_tag_flag", 32'(unexp_tag), 32'h1);
        check("old_tag_no_done", 32'(dma_done), 32'h0);
        cpl(8'd0, 10'd1, 3'd0);
        tick();
        cpl_valid = 1'b0;
        check("post_rst_done", 32'(dma_done), 32'h1);
        tick();

        // Read tag 1, completion with bad status
        issue(32'h0000_0400, 32'h0, 10'd8, 1'b0);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        cpl(8'd1, 10'd2, 3'b001);
        tick();
        cpl_valid = 1'b0;
        check("bad_status_flags", flags(), 32'h0000_000B);
        dma_pending = 1'b1; dma_size = 10'd8;
        tick(); tick();
        dma_pending = 1'b0;
        check("bad_status_sticky", flags(), 32'h0000_000B);

        // Zero size
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        issue(32'h0000_0800, 32'h0, 10'd0, 1'b0);
        check("zero_size_flags", flags(), 32'h0000_000C);
        tick();
        check("zero_size_sticky", flags(), 32'h0000_000C);

`ifdef DMA_CPL_TIMEOUT_EN
        // Completion timeout after 100 waiting cycles
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        issue(32'h0000_0800, 32'h0, 10'd4, 1'b0);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        check("timeout_not_yet", 32'(err), 32'h0);
        tick();
        check("timeout_flags", flags(), 32'h0000_000E);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dma_request_issuer.md
# dma_request_issuer

Consumes one DMA chunk at a time from the transmission splitter and turns it into a single PCIe memory-request TLP header (MRd for reads, MWr for writes) on a valid/ready header port. For reads it tracks the matching completions, produces the device-side write address for completion data, and pulses `dma_done` once the full chunk has arrived. For writes it pulses `dma_done` once the header is accepted; payload streaming belongs to the TX data mover. It sits directly downstream of the splitter and upstream of the PCIe TX/RX core interface.

## Interface
- `CPL_TIMEOUT_CYCLES`, 65535, completion-timeout limit in cycles (16-bit); used only with the timeout macro.
- `i_clk  in  1  clock`
- `i_rst  in  1  reset; synchronous, active-high; clock i_clk`
- `dma_pending  in  1  chunk request (level)`
- `dma_address_host  in  32  host byte address; bits [1:0] ignored`
- `dma_address_device  in  32  device byte address for completion data`
- `dma_size  in  10  chunk size in bytes; 0 is illegal`
- `dma_dir_write  in  1  1 = MWr, 0 = MRd`
- `dma_done  out  1  one-cycle chunk-complete pulse`
- `requester_id  in  16  bus/dev/fn inserted into DW1`
- `hdr_valid  out  1  header valid`
- `hdr_ready  in  1  header accepted`
- `hdr_dw0 / hdr_dw1 / hdr_dw2  out  32 each  3DW header`
- `cpl_valid  in  1  completion header strobe`
- `cpl_tag  in  8  completion tag`
- `cpl_length_dw  in  10  payload DWs in this completion`
- `cpl_status  in  3  completion status; 0 = SC`
- `cpl_wr_address  out  32  device address for the current completion's payload`
- `err  out  1  sticky fatal error`
- `err_code  out  2  01 = bad status, 10 = zero size, 11 = timeout`
- `unexp_tag  out  1  sticky flag: completion with a non-matching tag seen`

## Operation
- States: IDLE, HDR, WAIT_CPL, DONE, ERR.
- IDLE: `dma_pending`=1 → latch address, size, direction and the current tag, then go to HDR.
  - If `dma_size`=0: go to ERR with code 10.
- Length: `len_dw = (dma_size+3)>>2`, 10-bit.
- Byte enables: last BE from `dma_size[1:0]`: 00→F, 01→1, 10→3, 11→7.
  - `len_dw`>1: first BE = F.
  - `len_dw`=1: first BE = the last-BE pattern, and last BE = 0.
- Header:
  - DW0 = {fmt, type 5'b00000, 6'b0, TC/attr 0, length}; fmt is 3'b000 for MRd, 3'b010 for MWr.
  - DW1 = {requester_id, 3'b0, tag[4:0], lastBE, firstBE}.
  - DW2 = {addr[31:2], 2'b00}.
- HDR: `hdr_valid`=1 with the header stable until `hdr_ready`.
  - On handshake, tag increments (5-bit, wraps 31→0).
  - Next state is DONE for writes, WAIT_CPL for reads.
- WAIT_CPL:
  - `cpl_valid` with `cpl_tag`=={3'b0,tag} and status 0: `rcv_dw += cpl_length_dw`.
  - `cpl_wr_address` = device base + (`rcv_dw`<<2), using `rcv_dw` before the add. It is valid in the same cycle as `cpl_valid`, computed combinationally from registered state.
  - When `rcv_dw + cpl_length_dw >= len_dw`, go to DONE.
  - Matching tag with status ≠0: go to ERR, code 01.
  - Non-matching tag: ignored; set `unexp_tag`.
- DONE: `dma_done`=1 for exactly one cycle, then IDLE.
- Guard cycle: IDLE does not sample `dma_pending` until the cycle after `dma_done`. By then the splitter has advanced its address and size registers.
- ERR: holds until reset.
  - `err`=1 and `err_code` stays valid.
  - `dma_done` is never asserted; `hdr_valid`=0.

## Timing
- Reset values:
  - Outputs: `dma_done`=0, `hdr_valid`=0, `hdr_dw*`=0, `cpl_wr_address`=0, `err`=0, `err_code`=0, `unexp_tag`=0.
  - Internal: tag=0, state IDLE.
- `dma_pending` sampled at edge k → `hdr_valid`=1 in cycle k+1.
- Write path: handshake at edge m → `dma_done`=1 in cycle m+1 → IDLE in m+2.
- Read path: final completion sampled at edge c → `dma_done`=1 in cycle c+1.
- `hdr_valid` and header fields are registered and never drop without `hdr_ready`.
- Reset mid-operation: any state goes to IDLE next edge. Outstanding completions are then ignored, but a mismatched tag still sets `unexp_tag`.
- `cpl_valid` outside WAIT_CPL: ignored, no flag.
- `rcv_dw` is 11-bit; overshoot (completions exceeding `len_dw`) is tolerated and ends the chunk.

## Configuration
- `DMA_CPL_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering WAIT_CPL and on each matching completion, and increments otherwise.
  - Reaching `CPL_TIMEOUT_CYCLES` → ERR, code 11.
- Undefined: no counter; WAIT_CPL waits indefinitely; code 11 is never produced.

## Test plan
- Read, host 0x1000_0000, size 128, requester_id 0x0100, tag 0.
  - Header: DW0 0x0000_0020, DW1 0x0100_00FF, DW2 0x1000_0000.
  - Two tag-0 completions of 16 DW: `cpl_wr_address` = base, then base+64.
  - `dma_done` in the cycle after the second completion.
- Write, size 256, `hdr_ready` delayed 3 cycles.
  - DW0 0x4000_0040; header held stable throughout.
  - `dma_done` 1 cycle after the handshake; next header carries tag 1.
- Sizes 6 and 3.
  - Size 6: DW0 length 2, DW1[7:0]=0x3F.
  - Size 3: length 1, DW1[7:0]=0x07.
- Completion with status 3'b001 → `err`=1, `err_code`=01, no `dma_done`.
- Completion with the wrong tag → `unexp_tag`=1, chunk still completes on the correct tag.
  - Size 0 → ERR, code 10.
- With `DMA_CPL_TIMEOUT_EN` and `CPL_TIMEOUT_CYCLES`=100, no completion → ERR, code 11 after 100 cycles.
  - Assert `i_rst` mid-WAIT_CPL → all outputs at reset values, tag 0.
